hdmi_pixel_fifo: RTL and testbench
==================================

Name: hdmi_pixel_fifo

Overview:
Pixel-clock-domain elastic buffer directly upstream of the HDMI output stage. It accepts a 24-bit RGB pixel stream with start-of-frame marking from the accelerator/video source using a valid/ready handshake. It presents pixels on po_red/po_green/po_blue in the same cycle the HDMI stage asserts stream_ready (its draw area). It keeps frames aligned to the HDMI raster, recovers from underrun and misalignment, and blanks the output while unlocked.

Parameters:
DEPTH, 1024, FIFO depth in pixels; power of 2, minimum 4.
HPIX, 640, active pixels per line.
VPIX, 480, active lines per frame.
BLANK_COLOR, 24'h000000, {R,G,B} driven whenever no valid pixel is presented.

Ports:
pi_clk  in  1  pixel clock; same clock as the HDMI stage.
pi_rst  in  1  synchronous reset, active-high.
pi_valid  in  1  input pixel valid.
pi_sof  in  1  input pixel is the first pixel of a frame (x=0, y=0).
pi_data  in  24  input pixel {R[23:16],G[15:8],B[7:0]}.
po_ready  out  1  FIFO can accept a word this cycle.
pi_stream_ready  in  1  HDMI draw-area strobe; one pixel is consumed every cycle it is high.
po_red  out  8  pixel red.
po_green  out  8  pixel green.
po_blue  out  8  pixel blue.
po_locked  out  1  high in STREAM state.
po_underrun  out  1  sticky; FIFO was empty on a consume cycle while locked.
po_sof_err  out  1  sticky; SOF flag did not match raster frame start while locked.
pi_clear_err  in  1  clears both sticky flags.
po_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset and clock: one clock, pi_clk. pi_rst is synchronous and active-high.
- Reset values: state=RESYNC, FIFO empty, po_level=0, rd_cnt=0, po_locked=0, po_underrun=0, po_sof_err=0, po_ready=1. RGB outputs = BLANK_COLOR.
- Reset mid-operation: FIFO contents are discarded, all state returns to the reset values above.
- Storage: 25-bit words {sof, data}, first-word-fall-through with asynchronous read of the head.
  - A word written in cycle t is visible at the head from t+1.
  - Write and pop in the same cycle are allowed: level is unchanged.
- Write handshake: a word is accepted when pi_valid && po_ready. po_ready = !full, with no combinational dependence on pi_stream_ready. Writes while full are impossible by construction.
- rd_cnt: counts pi_stream_ready cycles modulo HPIX*VPIX in every state. It wraps from HPIX*VPIX-1 to 0. Raster frame start is defined as pi_stream_ready && rd_cnt==0. rd_cnt is aligned to the HDMI counters because both share reset.
- Output mux (combinational): RGB = FIFO head data when a pop occurs this cycle, otherwise BLANK_COLOR.
- State machine:
  - RESYNC:
    - FIFO held flushed; po_ready=1.
    - Input words are discarded until pi_valid && pi_sof. That word is written and the state moves to ALIGN.
  - ALIGN:
    - Normal writes; no pops; output BLANK_COLOR.
    - On raster frame start with the FIFO non-empty: pop the head (its sof flag is 1 by construction), present it, set po_locked, go to STREAM.
    - If the FIFO is empty at raster frame start, stay in ALIGN.
  - STREAM:
    - Every pi_stream_ready cycle pops one word and presents it.
    - Empty FIFO on pi_stream_ready: output BLANK_COLOR, set po_underrun, flush, go to RESYNC.
    - Popped word sof=1 with rd_cnt!=0, or sof=0 with rd_cnt==0: the pixel is still presented this cycle, po_sof_err is set, flush next cycle, go to RESYNC.
    - po_locked drops the cycle after leaving STREAM.
- Sticky flags: cleared by pi_clear_err. If a set event and pi_clear_err occur in the same cycle, the set wins.
- Latency: minimum input-to-output latency is 1 cycle (write at t, earliest presented at t+1).

Test Plan:
- Lock and stream: HPIX=4, VPIX=2, DEPTH=8. After reset, write an 8-pixel frame 0x000001..0x000008 with sof on the first pixel. Then assert stream_ready for 8 cycles starting at rd_cnt=0 -> outputs 0x000001..0x000008 in order, po_locked=1, no errors.
- Pre-SOF discard: write 0xAAAAAA and 0xBBBBBB without sof, then a frame starting at 0x000010 with sof -> first presented pixel is 0x000010 and po_level never counts the discarded words.
- Underrun: lock, then supply only 5 of 8 pixels -> 6th stream_ready cycle outputs 0x000000, po_underrun=1, po_locked=0 next cycle. Relock happens on the next sof plus the next rd_cnt==0.
- SOF misalignment: lock, then insert a sof word at frame pixel 3 -> that pixel is presented, po_sof_err=1, return to RESYNC.
- Full/backpressure: fill 8 words without stream_ready -> po_ready=0, po_level=8. Then one cycle of stream_ready with pi_valid=1 -> po_level stays 8 and po_ready stays 0.
- Clear vs set and reset: pi_clear_err asserted in the same cycle as a new underrun -> po_underrun stays 1. pi_rst asserted mid-frame -> po_level=0, outputs BLANK, and the next cycle is in RESYNC.

Source files
------------

// File: rtl/hdmi_pixel_fifo.sv
// Pixel-domain elastic buffer feeding the HDMI output stage.
// Stores {sof, rgb} words in a first-word-fall-through FIFO and locks the
// stream to the HDMI raster. It drops back to resync on underrun or when the
// sof flag and the raster disagree, and drives the blank colour while unlocked.
module hdmi_pixel_fifo #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned HPIX        = 640,
    parameter int unsigned VPIX        = 480,
    parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
    input  logic                     pi_clk,
    input  logic                     pi_rst,
    input  logic                     pi_valid,
    input  logic                     pi_sof,
    input  logic [23:0]              pi_data,
    output logic                     po_ready,
    input  logic                     pi_stream_ready,
    output logic [7:0]               po_red,
    output logic [7:0]               po_green,
    output logic [7:0]               po_blue,
    output logic                     po_locked,
    output logic                     po_underrun,
    output logic                     po_sof_err,
    input  logic                     pi_clear_err,
    output logic [$clog2(DEPTH):0]   po_level
);

    localparam int unsigned AddrW    = $clog2(DEPTH);
    localparam int unsigned LevelW   = AddrW + 1;
    localparam int unsigned FrameLen = HPIX * VPIX;
    localparam int unsigned CntW     = (FrameLen > 1) ? $clog2(FrameLen) : 1;

    typedef enum logic [1:0] {
        StResync,
        StAlign,
        StStream
    } state_e;

    state_e state_q, state_d;

    logic [24:0]       mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic              underrun_q, underrun_d;
    logic              sof_err_q, sof_err_d;

    logic        full;
    logic        empty;
    logic [24:0] head;
    logic        head_sof;
    logic        cnt_zero;
    logic        frame_start;
    logic        accept;
    logic        sof_mismatch;

    logic        wr_en;
    logic        pop;
    logic        flush;
    logic        underrun_set;
    logic        sof_err_set;
    logic [23:0] rgb;

    assign full         = (level_q == LevelW'(DEPTH));
    assign empty        = (level_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign head_sof     = head[24];
    assign cnt_zero     = (rd_cnt_q == '0);
    assign frame_start  = pi_stream_ready && cnt_zero;
    assign accept       = pi_valid && !full;
    // Head sof must coincide exactly with raster position 0.
    assign sof_mismatch = (head_sof != cnt_zero);

    // State register.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state_q <= StResync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StResync: begin
                if (pi_valid && pi_sof) begin
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (frame_start && !empty) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (pi_stream_ready && (empty || sof_mismatch)) begin
                    state_d = StResync;
                end
            end
            default: state_d = StResync;
        endcase
    end

    // FSM outputs: FIFO strobes and error events.
    always_comb begin
        wr_en        = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        underrun_set = 1'b0;
        sof_err_set  = 1'b0;
        case (state_q)
            StResync: begin
                // Everything before a start-of-frame word is dropped.
                wr_en = accept && pi_sof;
            end
            StAlign: begin
                wr_en = accept;
                pop   = frame_start && !empty;
            end
            StStream: begin
                wr_en = accept;
                if (pi_stream_ready) begin
                    if (empty) begin
                        underrun_set = 1'b1;
                        flush        = 1'b1;
                    end else begin
                        // The pixel is still shown even when its sof flag is wrong.
                        pop = 1'b1;
                        if (sof_mismatch) begin
                            sof_err_set = 1'b1;
                            flush       = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // FIFO pointer/level, raster counter and sticky flag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AddrW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   level_d = level_q + LevelW'(1);
                2'b01:   level_d = level_q - LevelW'(1);
                default: level_d = level_q;
            endcase
        end

        rd_cnt_d = rd_cnt_q;
        if (pi_stream_ready) begin
            if (rd_cnt_q == CntW'(FrameLen - 1)) begin
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CntW'(1);
            end
        end

        // A set event beats a simultaneous clear.
        underrun_d = underrun_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (pi_clear_err) begin
            underrun_d = 1'b0;
        end

        sof_err_d = sof_err_q;
        if (sof_err_set) begin
            sof_err_d = 1'b1;
        end else if (pi_clear_err) begin
            sof_err_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_cnt_q   <= '0;
            underrun_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_cnt_q   <= rd_cnt_d;
            underrun_q <= underrun_d;
            sof_err_q  <= sof_err_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge pi_clk) begin
        if (wr_en && !flush && !pi_rst) begin
            mem_q[wr_ptr_q] <= {pi_sof, pi_data};
        end
    end

    // Output mux: head word only on a pop cycle, blank otherwise.
    always_comb begin
        rgb = BLANK_COLOR;
        if (pop) begin
            rgb = head[23:0];
        end
    end

    assign po_red      = rgb[23:16];
    assign po_green    = rgb[15:8];
    assign po_blue     = rgb[7:0];
    assign po_ready    = !full;
    assign po_locked   = (state_q == StStream);
    assign po_underrun = underrun_q;
    assign po_sof_err  = sof_err_q;
    assign po_level    = level_q;

endmodule

// File: tb/tb_hdmi_pixel_fifo.sv
// Self-checking bench for hdmi_pixel_fifo with a queue-based reference model.
module tb_hdmi_pixel_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned HPIX  = 4;
    localparam int unsigned VPIX  = 2;
    localparam int unsigned FRAME = HPIX * VPIX;
    localparam logic [23:0] BLANK = 24'h000000;

    logic        pi_clk = 1'b0;
    logic        pi_rst = 1'b0;
    logic        pi_valid = 1'b0;
    logic        pi_sof = 1'b0;
    logic [23:0] pi_data = '0;
    logic        po_ready;
    logic        pi_stream_ready = 1'b0;
    logic [7:0]  po_red, po_green, po_blue;
    logic        po_locked, po_underrun, po_sof_err;
    logic        pi_clear_err = 1'b0;
    logic [3:0]  po_level;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 pi_clk = ~pi_clk;

    hdmi_pixel_fifo #(
        .DEPTH(DEPTH),
        .HPIX(HPIX),
        .VPIX(VPIX),
        .BLANK_COLOR(BLANK)
    ) dut (
        .pi_clk(pi_clk),
        .pi_rst(pi_rst),
        .pi_valid(pi_valid),
        .pi_sof(pi_sof),
        .pi_data(pi_data),
        .po_ready(po_ready),
        .pi_stream_ready(pi_stream_ready),
        .po_red(po_red),
        .po_green(po_green),
        .po_blue(po_blue),
        .po_locked(po_locked),
        .po_underrun(po_underrun),
        .po_sof_err(po_sof_err),
        .pi_clear_err(pi_clear_err),
        .po_level(po_level)
    );

    // Reference model: behavioural modes, a word queue and a raster position.
    typedef enum int {MResync, MAlign, MStream} mode_t;
    mode_t       m_mode = MResync;
    logic [24:0] m_q[$];
    int          m_cnt = 0;
    bit          m_unf = 0;
    bit          m_serr = 0;

    bit          ev_pop, ev_unf, ev_serr;
    logic        exp_ready;
    logic [23:0] exp_rgb;
    logic [3:0]  exp_level;
    logic        exp_locked, exp_unf, exp_serr;

    function automatic logic [31:0] dut_obs();
        return {po_ready, po_red, po_green, po_blue, po_locked, po_underrun, po_sof_err, po_level};
    endfunction

    function automatic logic [31:0] mdl_obs();
        return {exp_ready, exp_rgb, exp_locked, exp_unf, exp_serr, exp_level};
    endfunction

    function automatic logic [23:0] dut_rgb();
        return {po_red, po_green, po_blue};
    endfunction

    // Drive one cycle of inputs and derive what the outputs must be before the edge.
    task automatic apply(input bit v, input bit s, input logic [23:0] d, input bit sr,
                         input bit clr, input bit rst);
        pi_valid = v;
        pi_sof = s;
        pi_data = d;
        pi_stream_ready = sr;
        pi_clear_err = clr;
        pi_rst = rst;
        ev_pop = 0;
        ev_unf = 0;
        ev_serr = 0;
        case (m_mode)
            MAlign: ev_pop = sr && (m_cnt == 0) && (m_q.size() > 0);
            MStream: begin
                if (sr) begin
                    if (m_q.size() == 0) begin
                        ev_unf = 1;
                    end else begin
                        ev_pop = 1;
                        ev_serr = (m_q[0][24] != (m_cnt == 0));
                    end
                end
            end
            default: ;
        endcase
        exp_ready = (m_q.size() < DEPTH);
        exp_rgb = ev_pop ? m_q[0][23:0] : BLANK;
        exp_level = 4'(m_q.size());
        exp_locked = (m_mode == MStream);
        exp_unf = m_unf;
        exp_serr = m_serr;
        @(negedge pi_clk);
    endtask

    // Clock edge: advance the model with the inputs that were applied.
    task automatic tick();
        bit acc;
        acc = pi_valid && exp_ready;
        @(posedge pi_clk);
        if (pi_rst) begin
            m_q.delete();
            m_cnt = 0;
            m_mode = MResync;
            m_unf = 0;
            m_serr = 0;
        end else begin
            if (ev_unf) m_unf = 1;
            else if (pi_clear_err) m_unf = 0;
            if (ev_serr) m_serr = 1;
            else if (pi_clear_err) m_serr = 0;
            case (m_mode)
                MResync: begin
                    if (pi_valid && pi_sof) begin
                        m_q.delete();
                        m_q.push_back({1'b1, pi_data});
                        m_mode = MAlign;
                    end
                end
                MAlign: begin
                    if (ev_pop) begin
                        void'(m_q.pop_front());
                        m_mode = MStream;
                    end
                    if (acc) m_q.push_back({pi_sof, pi_data});
                end
                default: begin
                    if (ev_unf || ev_serr) begin
                        m_q.delete();
                        m_mode = MResync;
                    end else begin
                        if (ev_pop) void'(m_q.pop_front());
                        if (acc) m_q.push_back({pi_sof, pi_data});
                    end
                end
            endcase
            if (pi_stream_ready) m_cnt = (m_cnt + 1) % FRAME;
        end
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, '0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        apply(0, 0, '0, 1, 0, 0);
        tests_run++;
        if (dut_obs() !== {1'b1, BLANK, 3'b000, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got %h want %h", dut_obs(), {1'b1, BLANK, 3'b000, 4'd0});
        end
        tests_run++;
        if (dut_obs() !== mdl_obs()) begin
            tests_failed++;
            $display("FAIL reset_model: got %h want %h", dut_obs(), mdl_obs());
        end
        tick();
    endtask

    task automatic test_lock_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'(i + 1), 0, 0, 0);
            tests_run++;
            if (dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL lock_fill[%0d]: got %h want %h", i, dut_obs(), mdl_obs());
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tests_run++;
            if (dut_rgb() !== 24'(i + 1) || dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL lock_stream[%0d]: got %h want rgb %h model %h",
                         i, dut_obs(), 24'(i + 1), mdl_obs());
            end
            tick();
        end
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if ({po_locked, po_underrun, po_sof_err} !== 3'b100) begin
            tests_failed++;
            $display("FAIL lock_status: got %b want 100", {po_locked, po_underrun, po_sof_err});
        end
        tick();
    endtask

    task automatic test_pre_sof_discard();
        logic [23:0] junk[2];
        junk[0] = 24'hAAAAAA;
        junk[1] = 24'hBBBBBB;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, junk[i], 0, 0, 0);
            tick();
        end
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if (po_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL discard_level: got %0d want 0", po_level);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'(16 + i), 0, 0, 0);
            tick();
        end
        apply(0, 0, '0, 1, 0, 0);
        tests_run++;
        if (dut_rgb() !== 24'h000010 || po_level !== 4'd8) begin
            tests_failed++;
            $display("FAIL discard_first: got rgb %h level %0d want 000010 level 8",
                     dut_rgb(), po_level);
        end
        tick();
    endtask

    task automatic test_underrun();
        logic [23:0] px[8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'($urandom), 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) px[i] = 24'($urandom_range(1, 24'hFFFFFF));
        for (int i = 0; i < 5; i++) begin
            apply(1, i == 0, px[i], 0, 0, 0);
            tick();
        end
        // Sixth consume also carries a clear: the new underrun must win.
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, '0, 1, i == 5, 0);
            tests_run++;
            if (dut_rgb() !== ((i < 5) ? px[i] : BLANK) || dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL underrun_out[%0d]: got %h want model %h", i, dut_obs(), mdl_obs());
            end
            tick();
        end
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if ({po_underrun, po_locked, po_level} !== {1'b1, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL underrun_flag: got unf %b lock %b lvl %0d want 1 0 0",
                     po_underrun, po_locked, po_level);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, px[i], 0, 0, 0);
            tick();
        end
        // Raster sits at 6: two more consume slots before position 0 relocks.
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tests_run++;
            if (dut_rgb() !== ((i == 2) ? px[0] : (i == 3) ? px[1] : BLANK) ||
                dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL relock[%0d]: got %h want model %h", i, dut_obs(), mdl_obs());
            end
            tick();
        end
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if (po_locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_state: got %b want 1", po_locked);
        end
        tick();
    endtask

    task automatic test_sof_misalign();
        logic [23:0] px[8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'($urandom), 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            px[i] = 24'($urandom);
            apply(1, (i == 0) || (i == 3), px[i], 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tests_run++;
            if (dut_rgb() !== px[i] || dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL misalign_out[%0d]: got %h want rgb %h model %h",
                         i, dut_obs(), px[i], mdl_obs());
            end
            tick();
        end
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if ({po_sof_err, po_locked, po_underrun, po_level} !== {3'b100, 4'd0}) begin
            tests_failed++;
            $display("FAIL misalign_flag: got serr %b lock %b unf %b lvl %0d want 1 0 0 0",
                     po_sof_err, po_locked, po_underrun, po_level);
        end
        tick();
    endtask

    task automatic test_full_backpressure();
        do_reset();
        // Move the raster off position 0 so the later consume slot cannot pop.
        apply(0, 0, '0, 1, 0, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'($urandom), 0, 0, 0);
            tick();
        end
        apply(1, 0, 24'h123456, 1, 0, 0);
        tests_run++;
        if ({po_ready, po_level} !== {1'b0, 4'd8} || dut_obs() !== mdl_obs()) begin
            tests_failed++;
            $display("FAIL full_state: got rdy %b lvl %0d want 0 8", po_ready, po_level);
        end
        tick();
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if ({po_ready, po_level} !== {1'b0, 4'd8}) begin
            tests_failed++;
            $display("FAIL full_hold: got rdy %b lvl %0d want 0 8", po_ready, po_level);
        end
        tick();
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'($urandom), 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tick();
        end
        apply(0, 0, '0, 1, 1, 0);
        tick();
        apply(0, 0, '0, 0, 1, 0);
        tests_run++;
        if (po_underrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_vs_set: got %b want 1", po_underrun);
        end
        tick();
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if (po_underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_only: got %b want 0", po_underrun);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(1, i == 0, 24'($urandom), 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, '0, 1, 0, 0);
            tests_run++;
            if (dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL pre_rst[%0d]: got %h want %h", i, dut_obs(), mdl_obs());
            end
            tick();
        end
        apply(1, 0, 24'h55AA55, 1, 0, 1);
        tick();
        apply(1, 0, 24'h55AA55, 1, 0, 0);
        tests_run++;
        if (dut_obs() !== {1'b1, BLANK, 3'b000, 4'd0}) begin
            tests_failed++;
            $display("FAIL mid_reset: got %h want %h", dut_obs(), {1'b1, BLANK, 3'b000, 4'd0});
        end
        tick();
        apply(0, 0, '0, 0, 0, 0);
        tests_run++;
        if (po_level !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset_resync: got lvl %0d want 0", po_level);
        end
        tick();
    endtask

    task automatic test_random();
        int src_idx = 0;
        bit v, s, sr, clr, rst;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (src_idx == 0) ^ ($urandom_range(0, 49) == 0);
            sr = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 799) == 0);
            apply(v, s, 24'($urandom), sr, clr, rst);
            tests_run++;
            if (dut_obs() !== mdl_obs()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_obs(), mdl_obs());
            end
            if (v && exp_ready) src_idx = (src_idx + 1) % FRAME;
            tick();
        end
    endtask

    initial begin
        @(posedge pi_clk);
        #1;
        test_reset();
        test_lock_stream();
        test_pre_sof_discard();
        test_underrun();
        test_sof_misalign();
        test_full_backpressure();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
